// File: rtl/score_pkg.sv
// Shared definitions for the score window loader.
//   NOTE_REST / NOTE_END : note codes, sliced to NOTE_W by users (rest = 0, end = all-ones)
//   TEMPO_MIN            : shortest beat period; covers the two-cycle ROM prefetch
//   state_t              : sequencer states
package score_pkg;

    localparam logic [31:0] NOTE_REST = '0;
    localparam logic [31:0] NOTE_END  = '1;
    localparam int unsigned TEMPO_MIN = 3;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/score_window_loader_if.sv
// ROM fetch bus between the score window loader and the song ROMs.
//   rom_addr : {song, note index}, driven by the loader (master)
//   rom_data : note code, valid one cycle after rom_addr (driven by the ROM, slave)
interface score_window_loader_if #(
    parameter int unsigned NOTE_W = 4,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned SONG_W = 2
) ();

    logic [SONG_W+ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0]        rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );

endinterface

// File: rtl/score_beat_timer.sv
// Beat period timer for the score window loader.
//   clk, reset : clock, synchronous active-high reset
//   start      : latch tempo_in (clamped to TEMPO_MIN) and restart the count at 0
//   pause      : level, freezes the counter and suppresses tick
//   run        : sequencer is in PLAY or DRAIN; counter is held at 0 otherwise
//   tempo_in   : beat period in cycles
//   tick       : high in the cycle whose clock edge shifts the window
module score_beat_timer
    import score_pkg::*;
#(
    parameter int unsigned TEMPO_W = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               run,
    input  logic [TEMPO_W-1:0] tempo_in,
    output logic               tick
);

    localparam logic [TEMPO_W-1:0] MIN_PERIOD = TEMPO_W'(TEMPO_MIN);
    localparam logic [TEMPO_W-1:0] ONE        = TEMPO_W'(1);

    logic [TEMPO_W-1:0] period_q;
    logic [TEMPO_W-1:0] cnt_q;
    logic               at_last;

    assign at_last = (cnt_q == period_q - ONE);
    // start wins over a tick that would otherwise land in the same cycle
    assign tick    = run && !pause && !start && at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= MIN_PERIOD;
            cnt_q    <= '0;
        end else if (start) begin
            period_q <= (tempo_in < MIN_PERIOD) ? MIN_PERIOD : tempo_in;
            cnt_q    <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (!pause) begin
            cnt_q <= at_last ? '0 : cnt_q + ONE;
        end
    end

endmodule

// File: rtl/score_window_loader.sv
// Score sequencer: fetches one note per beat from the song ROM and presents a DEPTH-note
// lookahead window to the note-highway renderer.
//   clk, reset  : clock, synchronous active-high reset
//   start       : pulse, latch song_id/tempo_in and (re)start from note 0
//   pause       : level, freezes beat counter, window, address and state
//   song_id     : song select, sampled on start
//   tempo_in    : beat period in cycles, sampled on start (0..2 run as 3)
//   rom         : ROM fetch bus (master side)
//   window_out  : note[DEPTH-1] (newest) in MSBs .. note[0] (current) in LSBs
//   beat        : 1-cycle pulse on every window shift
//   playing     : high in PLAY or DRAIN
//   song_done   : 1-cycle pulse when the song finishes (or wraps, in loop mode)
// Build option: define SCORE_LOOP_EN to loop the song on the end marker instead of draining.
module score_window_loader
    import score_pkg::*;
#(
    parameter int unsigned NOTE_W  = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned SONG_W  = 2,
    parameter int unsigned TEMPO_W = 26
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic [SONG_W-1:0]         song_id,
    input  logic [TEMPO_W-1:0]        tempo_in,
    score_window_loader_if.master     rom,
    output logic [DEPTH*NOTE_W-1:0]   window_out,
    output logic                      beat,
    output logic                      playing,
    output logic                      song_done
);

    localparam int unsigned     CNT_W   = $clog2(DEPTH + 1);
    localparam logic [NOTE_W-1:0] REST  = NOTE_REST[NOTE_W-1:0];
    localparam logic [NOTE_W-1:0] ENDM  = NOTE_END[NOTE_W-1:0];
    localparam logic [ADDR_W-1:0] IDX_MAX = '1;

    state_t                   state_q;
    logic [SONG_W-1:0]        song_q;
    logic [ADDR_W-1:0]        idx_q;
    logic [NOTE_W-1:0]        next_note_q;
    logic                     next_valid_q;
    logic                     fetch_p1_q;
    logic                     fetch_p2_q;
    logic [CNT_W-1:0]         drain_cnt_q;
    logic [DEPTH*NOTE_W-1:0]  window_q;

    logic                     tick;
    logic                     run;
    logic                     at_end;
    logic [NOTE_W-1:0]        ins_note;

    assign run        = (state_q == PLAY) || (state_q == DRAIN);
    // Hitting the last address is treated exactly like fetching the end marker.
    assign at_end     = (next_valid_q && (next_note_q == ENDM)) || (idx_q == IDX_MAX);
    assign ins_note   = next_valid_q ? next_note_q : REST;
    assign rom.rom_addr = {song_q, idx_q};
    assign window_out = window_q;

    score_beat_timer #(
        .TEMPO_W (TEMPO_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .run      (run),
        .tempo_in (tempo_in),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            song_q       <= '0;
            idx_q        <= '0;
            next_note_q  <= REST;
            next_valid_q <= 1'b0;
            fetch_p1_q   <= 1'b0;
            fetch_p2_q   <= 1'b0;
            drain_cnt_q  <= '0;
            window_q     <= '0;
            beat         <= 1'b0;
            playing      <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            beat      <= 1'b0;
            song_done <= 1'b0;

            // Address change -> ROM samples next edge -> data captured the edge after.
            fetch_p1_q <= 1'b0;
            fetch_p2_q <= fetch_p1_q;
            if (fetch_p2_q) begin
                next_note_q  <= rom.rom_data;
                next_valid_q <= 1'b1;
            end else if (tick) begin
                next_valid_q <= 1'b0;
            end

            if (start) begin
                state_q      <= PLAY;
                song_q       <= song_id;
                idx_q        <= '0;
                window_q     <= '0;
                fetch_p1_q   <= 1'b1;
                fetch_p2_q   <= 1'b0;
                next_valid_q <= 1'b0;
                drain_cnt_q  <= '0;
                playing      <= 1'b1;
            end else if (tick) begin
                beat <= 1'b1;
                unique case (state_q)
                    PLAY: begin
                        if (at_end) begin
                            window_q <= {REST, window_q[DEPTH*NOTE_W-1:NOTE_W]};
`ifdef SCORE_LOOP_EN
                            idx_q      <= '0;
                            fetch_p1_q <= 1'b1;
                            song_done  <= 1'b1;
`else
                            // The marker beat itself is the first of DEPTH rest beats.
                            state_q     <= DRAIN;
                            drain_cnt_q <= CNT_W'(1);
`endif
                        end else begin
                            window_q   <= {ins_note, window_q[DEPTH*NOTE_W-1:NOTE_W]};
                            idx_q      <= idx_q + ADDR_W'(1);
                            fetch_p1_q <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        window_q <= {REST, window_q[DEPTH*NOTE_W-1:NOTE_W]};
                        if (drain_cnt_q == CNT_W'(DEPTH - 1)) begin
                            state_q   <= DONE;
                            song_done <= 1'b1;
                            playing   <= 1'b0;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_window_loader.sv
// Directed bench for score_window_loader with a synchronous ROM model.
// Define SCORE_LOOP_EN for both RTL and bench to exercise the looping build.
module tb_score_window_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic [1:0]  song_id;
    logic [25:0] tempo_in;
    logic [63:0] window_out;
    logic        beat;
    logic        playing;
    logic        song_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] rom_mem [512];

    score_window_loader_if #(.NOTE_W(4), .ADDR_W(7), .SONG_W(2)) rom_if ();

    score_window_loader #(
        .NOTE_W  (4),
        .DEPTH   (16),
        .ADDR_W  (7),
        .SONG_W  (2),
        .TEMPO_W (26)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .song_id    (song_id),
        .tempo_in   (tempo_in),
        .rom        (rom_if),
        .window_out (window_out),
        .beat       (beat),
        .playing    (playing),
        .song_done  (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] s, input logic [25:0] t);
        song_id  = s;
        tempo_in = t;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Cycles until the next beat, or -1 if none within the budget.
    task automatic wait_beat(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (beat) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int beats;
        int dones;
        int done_at;
        int last_beat;

        for (int i = 0; i < 512; i++) rom_mem[i] = 4'h0;
        for (int i = 0; i < 15; i++) rom_mem[128 + i] = 4'(i + 1);  // song 1: 1..F
        for (int i = 0; i < 5; i++) rom_mem[256 + i] = 4'(i + 1);   // song 2: 1..5, end
        rom_mem[256 + 5] = 4'hF;
        rom_mem[384] = 4'h7;                                          // song 3: 7,9,end
        rom_mem[385] = 4'h9;
        rom_mem[386] = 4'hF;
        rom_mem[0] = 4'h1;                                            // song 0: 1,2,3,end
        rom_mem[1] = 4'h2;
        rom_mem[2] = 4'h3;
        rom_mem[3] = 4'hF;

        reset = 1'b1; start = 1'b0; pause = 1'b0; song_id = '0; tempo_in = '0;
        repeat (3) step();
        reset = 1'b0;
        repeat (50) step();
        check("idle_window", window_out, 64'h0);
        check("idle_beat", beat, 0);
        check("idle_playing", playing, 0);
        check("idle_addr", rom_if.rom_addr, 0);
        check("idle_done", song_done, 0);

        // Song 1 at tempo 10
        pulse_start(2'd1, 26'd10);
        check("start_playing", playing, 1);
        check("start_addr", rom_if.rom_addr, 9'h080);
        wait_beat(n);
        check("first_beat_lat", n, 10);
        check("beat1_window", window_out, 64'h1000_0000_0000_0000);
        check("beat1_addr", rom_if.rom_addr, 9'h081);
        step();
        check("beat_one_cycle", beat, 0);
        wait_beat(n);
        check("beat2_lat", n, 9);
        check("beat2_window", window_out, 64'h2100_0000_0000_0000);
        check("beat2_addr", rom_if.rom_addr, 9'h082);

        // Pause 40 cycles with 3 counts already elapsed
        repeat (3) step();
        pause = 1'b1;
        beats = 0;
        repeat (40) begin
            step();
            if (beat) beats++;
        end
        check("pause_no_beats", beats, 0);
        check("pause_window", window_out, 64'h2100_0000_0000_0000);
        check("pause_addr", rom_if.rom_addr, 9'h082);
        pause = 1'b0;
        wait_beat(n);
        check("pause_resume_lat", n, 7);
        check("beat3_window", window_out, 64'h3210_0000_0000_0000);

`ifndef SCORE_LOOP_EN
        // Song 2, tempo 0 (runs at 3): end marker at index 5, then drain
        pulse_start(2'd2, 26'd0);
        check("s2_addr", rom_if.rom_addr, 9'h100);
        beats = 0; done_at = -1; last_beat = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (beat) begin
                beats++;
                if (beats == 1) check("t0_first_lat", i, 3);
                if (beats == 2) check("t0_gap", i - last_beat, 3);
                if (beats == 5) check("s2_beat5_window", window_out, 64'h5432_1000_0000_0000);
                if (beats == 6) begin
                    check("drain_addr_hold", rom_if.rom_addr, 9'h105);
                    check("drain_playing", playing, 1);
                    check("drain_done_low", song_done, 0);
                end
                last_beat = i;
            end
            if (song_done) begin
                done_at = beats;
                check("done_window", window_out, 64'h0);
                check("done_playing", playing, 0);
                check("done_with_beat", beat, 1);
                break;
            end
        end
        check("done_beat_index", done_at, 21);
        step();
        check("done_pulse_once", song_done, 0);
        beats = 0;
        repeat (20) begin
            step();
            if (beat) beats++;
        end
        check("done_no_beats", beats, 0);

        // Restart mid-drain with song 3 at tempo 4
        pulse_start(2'd2, 26'd0);
        beats = 0; dones = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (beat) beats++;
            if (song_done) dones++;
            if (beats == 8) break;
        end
        check("mid_drain_reached", beats, 8);
        pulse_start(2'd3, 26'd4);
        check("restart_window", window_out, 64'h0);
        check("restart_addr", rom_if.rom_addr, 9'h180);
        check("restart_playing", playing, 1);
        wait_beat(n);
        check("restart_lat", n, 4);
        check("restart_window1", window_out, 64'h7000_0000_0000_0000);
        check("restart_addr1", rom_if.rom_addr, 9'h181);
        check("restart_no_done", dones, 0);
`else
        // Song 0, tempo 0: end at index 3 wraps back to 0
        pulse_start(2'd0, 26'd0);
        beats = 0; dones = 0; last_beat = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (song_done) dones++;
            if (beat) begin
                beats++;
                if (beats == 1) check("t0_first_lat", i, 3);
                if (beats == 2) check("t0_gap", i - last_beat, 3);
                if (beats == 4) begin
                    check("loop_done_pulse", song_done, 1);
                    check("loop_addr", rom_if.rom_addr, 9'h000);
                    check("loop_playing", playing, 1);
                    check("loop_window", window_out, 64'h0321_0000_0000_0000);
                end
                if (beats == 5) begin
                    check("loop_window2", window_out, 64'h1032_1000_0000_0000);
                    check("loop_addr2", rom_if.rom_addr, 9'h001);
                    break;
                end
                last_beat = i;
            end
        end
        check("loop_beats", beats, 5);
        check("loop_done_count", dones, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
